snn_batch_scheduler: RTL

//  Sequences multi-sample inference runs of the SNN core. For each spike-pattern batch it

---
 rtl/snn_batch_scheduler_if.sv | 76 +++++++
 rtl/snn_batch_scheduler.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/snn_batch_scheduler_if.sv
// -----------------------------------------------------------------------------
// snn_batch_scheduler_if
//
// Purpose
//   Bundles the signals of the SNN batch scheduler into one interface:
//   run control and status (towards axi_cfg_regs), shared-memory arbitration
//   (towards the host), and network / output-count RAM sequencing (towards
//   if_network, spike_pattern_mem and the output-count RAM).
//
// Parameters
//   BATCH_ADDR_WIDTH        width of the batch select (BW)
//   OUTPUT_SPIKE_ADDR_BITS  width of the output-neuron index (OA)
//   Both must match the parameters of the scheduler instance using it.
//
// Modports
//   slave   the scheduler: takes control inputs, drives status / sequencing
//   master  the controlling side (register block or testbench)
//
// Signal summary
//   start         1       1-cycle run request
//   abort         1       terminate current run
//   num_batches   BW+1    batches per run, sampled on start
//   sim_time      32      timesteps per batch, sampled on start
//   host_mem_req  1       host requests the shared memory port
//   host_mem_gnt  1       host owns the shared memory port
//   net_rst       1       network + spike-counter reset
//   net_step      1       timestep enable
//   batch_sel     BW      current spike-pattern batch
//   cnt_rd_idx    OA      spike-counter read index
//   cnt_wr_en     1       output-count RAM write strobe
//   cnt_wr_addr   BW+OA   {batch_sel, cnt_rd_idx}
//   busy          1       run in progress
//   done          1       sticky run-complete flag
//   aborted       1       sticky, last run ended by abort
//   irq           1       1-cycle pulse on run completion
// -----------------------------------------------------------------------------
interface snn_batch_scheduler_if #(
   parameter int BATCH_ADDR_WIDTH       = 6,
   parameter int OUTPUT_SPIKE_ADDR_BITS = 4
);

   // run control / status
   logic                                         start;
   logic                                         abort;
   logic [BATCH_ADDR_WIDTH:0]                    num_batches;
   logic [31:0]                                  sim_time;
   logic                                         busy;
   logic                                         done;
   logic                                         aborted;
   logic                                         irq;

   // shared memory arbitration
   logic                                         host_mem_req;
   logic                                         host_mem_gnt;

   // network and output-count RAM sequencing
   logic                                         net_rst;
   logic                                         net_step;
   logic [BATCH_ADDR_WIDTH-1:0]                  batch_sel;
   logic [OUTPUT_SPIKE_ADDR_BITS-1:0]            cnt_rd_idx;
   logic                                         cnt_wr_en;
   logic [BATCH_ADDR_WIDTH+OUTPUT_SPIKE_ADDR_BITS-1:0] cnt_wr_addr;

   modport slave (
      input  start, abort, num_batches, sim_time, host_mem_req,
      output host_mem_gnt, net_rst, net_step, batch_sel, cnt_rd_idx,
             cnt_wr_en, cnt_wr_addr, busy, done, aborted, irq
   );

   modport master (
      output start, abort, num_batches, sim_time, host_mem_req,
      input  host_mem_gnt, net_rst, net_step, batch_sel, cnt_rd_idx,
             cnt_wr_en, cnt_wr_addr, busy, done, aborted, irq
   );

endinterface

// File: rtl/snn_batch_scheduler.sv
// -----------------------------------------------------------------------------
// snn_batch_scheduler
//
// Purpose
//   Sequences multi-sample inference runs of the SNN core. For every batch of
//   a run it pulses the network reset, issues sim_time timestep enables
//   (STEP_CYCLES clocks apart), then drains the NUM_OUTPUTS spike counters
//   into the output-count RAM, one word per clock. The host gets the shared
//   RAM port only while the scheduler is idle (IDLE or DONE).
//
// Parameters
//   NUM_OUTPUTS             output neurons drained per batch (1..2**OA)
//   OUTPUT_SPIKE_ADDR_BITS  width of the output-neuron index (OA)
//   BATCH_ADDR_WIDTH        width of the batch select (BW)
//   STEP_CYCLES             clocks per timestep (>=1); net_step on the first
//
// Ports
//   S_AXI_ACLK     in   clock
//   S_AXI_ARESETN  in   asynchronous active-low reset
//   bus            snn_batch_scheduler_if.slave
//     in : start, abort, num_batches, sim_time, host_mem_req
//     out: host_mem_gnt (combinational), net_rst, net_step, batch_sel,
//          cnt_rd_idx, cnt_wr_en, cnt_wr_addr, busy, done, aborted, irq
//          (all registered)
// -----------------------------------------------------------------------------
module snn_batch_scheduler #(
   parameter int NUM_OUTPUTS            = 1,
   parameter int OUTPUT_SPIKE_ADDR_BITS = 4,
   parameter int BATCH_ADDR_WIDTH       = 6,
   parameter int STEP_CYCLES            = 2
) (
   input  logic                  S_AXI_ACLK,
   input  logic                  S_AXI_ARESETN,
   snn_batch_scheduler_if.slave  bus
);

   localparam int BW    = BATCH_ADDR_WIDTH;
   localparam int OA    = OUTPUT_SPIKE_ADDR_BITS;
   localparam int DIV_W = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;

   localparam logic [DIV_W-1:0] DIV_LAST    = DIV_W'(STEP_CYCLES - 1);
   localparam logic [OA-1:0]    OUT_LAST    = OA'(NUM_OUTPUTS - 1);
   localparam logic [BW:0]      MAX_BATCHES = {1'b1, {BW{1'b0}}};
   localparam logic [BW:0]      ONE_BATCH   = (BW+1)'(1);

   // FSM encoding
   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_RST   = 3'd1;
   localparam logic [2:0] S_RUN   = 3'd2;
   localparam logic [2:0] S_DRAIN = 3'd3;
   localparam logic [2:0] S_NEXT  = 3'd4;
   localparam logic [2:0] S_DONE  = 3'd5;

   // A run is in progress in every state except IDLE and DONE.
   function automatic logic is_active(input logic [2:0] s);
      return (s == S_RST) || (s == S_RUN) || (s == S_DRAIN) || (s == S_NEXT);
   endfunction

   // ---------------------------------------------------------------------------
   // State and counters
   // ---------------------------------------------------------------------------
   logic [2:0]       state_q,     state_d;
   logic [BW-1:0]    batch_idx_q, batch_idx_d;
   logic [31:0]      ts_cnt_q,    ts_cnt_d;
   logic [DIV_W-1:0] div_cnt_q,   div_cnt_d;
   logic [OA-1:0]    out_idx_q,   out_idx_d;
   logic [BW:0]      nb_q,        nb_d;
   logic [31:0]      sim_time_q,  sim_time_d;

   // Registered outputs
   logic             net_rst_q;
   logic             net_step_q;
   logic [BW-1:0]    batch_sel_q;
   logic [OA-1:0]    cnt_rd_idx_q;
   logic             cnt_wr_en_q;
   logic             busy_q;
   logic             done_q;
   logic             aborted_q;
   logic             irq_q;

   logic             accept;
   logic             abort_take;
   logic             done_entry;
   logic [BW:0]      nb_clamped;
   logic [BW:0]      nb_last;

   // A batch count wider than the addressable range runs every batch once.
   assign nb_clamped = (bus.num_batches > MAX_BATCHES) ? MAX_BATCHES : bus.num_batches;
   assign nb_last    = nb_q - ONE_BATCH;

   // abort only acts on a run in progress; it overrides every other transition.
   assign abort_take = bus.abort && is_active(state_q);

   // ---------------------------------------------------------------------------
   // Next-state logic
   // ---------------------------------------------------------------------------
   // NOTE: every variable gets a default at the top of the combinational block
   // so that no path leaves it unassigned (which would infer a latch); blocking
   // assignments are used here so later statements see the updated values.
   always_comb begin
      state_d     = state_q;
      batch_idx_d = batch_idx_q;
      ts_cnt_d    = ts_cnt_q;
      div_cnt_d   = div_cnt_q;
      out_idx_d   = out_idx_q;
      nb_d        = nb_q;
      sim_time_d  = sim_time_q;
      accept      = 1'b0;

      case (state_q)
         S_IDLE, S_DONE: begin
            // The host keeps the RAM port while it asks for it; a start in
            // that window is dropped rather than queued.
            if (bus.start && !bus.host_mem_req) begin
               accept      = 1'b1;
               nb_d        = nb_clamped;
               sim_time_d  = bus.sim_time;
               batch_idx_d = '0;
               state_d     = (nb_clamped == '0) ? S_DONE : S_RST;
            end
         end

         S_RST: begin
            ts_cnt_d  = '0;
            div_cnt_d = '0;
            out_idx_d = '0;
            state_d   = (sim_time_q == '0) ? S_DRAIN : S_RUN;
         end

         S_RUN: begin
            // ts_cnt counts the enables issued so far; the current cycle
            // carries one when div_cnt is 0.
            if (div_cnt_q == '0) begin
               ts_cnt_d = ts_cnt_q + 32'd1;
            end
            if (div_cnt_q == DIV_LAST) begin
               div_cnt_d = '0;
               if (ts_cnt_d == sim_time_q) begin
                  out_idx_d = '0;
                  state_d   = S_DRAIN;
               end
            end else begin
               div_cnt_d = div_cnt_q + DIV_W'(1);
            end
         end

         S_DRAIN: begin
            if (out_idx_q == OUT_LAST) begin
               state_d = S_NEXT;
            end else begin
               out_idx_d = out_idx_q + OA'(1);
            end
         end

         S_NEXT: begin
            if ({1'b0, batch_idx_q} == nb_last) begin
               state_d = S_DONE;
            end else begin
               batch_idx_d = batch_idx_q + BW'(1);
               state_d     = S_RST;
            end
         end

         default: state_d = S_IDLE;
      endcase

      if (abort_take) begin
         state_d = S_DONE;
      end
   end

   // Entering DONE, either from a run or straight from an accepted zero-batch
   // start (which can happen while already sitting in DONE).
   assign done_entry = (state_d == S_DONE) && ((state_q != S_DONE) || accept);

   // ---------------------------------------------------------------------------
   // Sequential state and registered outputs
   // ---------------------------------------------------------------------------
   // Outputs are computed from the next state so that they are valid in the
   // same cycle the FSM sits in the corresponding state.
   // NOTE: sequential state uses non-blocking assignments only, and every
   // flop, including the latched run parameters, has a defined reset value.
   always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
      if (!S_AXI_ARESETN) begin
         state_q      <= S_IDLE;
         batch_idx_q  <= '0;
         ts_cnt_q     <= '0;
         div_cnt_q    <= '0;
         out_idx_q    <= '0;
         nb_q         <= '0;
         sim_time_q   <= '0;
         net_rst_q    <= 1'b0;
         net_step_q   <= 1'b0;
         batch_sel_q  <= '0;
         cnt_rd_idx_q <= '0;
         cnt_wr_en_q  <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         aborted_q    <= 1'b0;
         irq_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         batch_idx_q  <= batch_idx_d;
         ts_cnt_q     <= ts_cnt_d;
         div_cnt_q    <= div_cnt_d;
         out_idx_q    <= out_idx_d;
         nb_q         <= nb_d;
         sim_time_q   <= sim_time_d;

         net_rst_q    <= (state_d == S_RST);
         net_step_q   <= (state_d == S_RUN) && (div_cnt_d == '0);
         cnt_wr_en_q  <= (state_d == S_DRAIN);
         cnt_rd_idx_q <= (state_d == S_DRAIN) ? out_idx_d : '0;
         busy_q       <= is_active(state_d);
         irq_q        <= done_entry;

         // batch_sel only moves when a batch starts, so it holds the last
         // batch after the run ends.
         if (state_d == S_RST) begin
            batch_sel_q <= batch_idx_d;
         end

         if (done_entry) begin
            done_q <= 1'b1;
         end else if (accept) begin
            done_q <= 1'b0;
         end

         if (abort_take) begin
            aborted_q <= 1'b1;
         end else if (accept) begin
            aborted_q <= 1'b0;
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Output mapping
   // ---------------------------------------------------------------------------
   assign bus.host_mem_gnt = bus.host_mem_req && ((state_q == S_IDLE) || (state_q == S_DONE));
   assign bus.net_rst      = net_rst_q;
   assign bus.net_step     = net_step_q;
   assign bus.batch_sel    = batch_sel_q;
   assign bus.cnt_rd_idx   = cnt_rd_idx_q;
   assign bus.cnt_wr_en    = cnt_wr_en_q;
   assign bus.cnt_wr_addr  = {batch_sel_q, cnt_rd_idx_q};
   assign bus.busy         = busy_q;
   assign bus.done         = done_q;
   assign bus.aborted      = aborted_q;
   assign bus.irq          = irq_q;

endmodule
